// File: rtl/aes_key_store_pkg.sv
// aes_key_store_pkg: shared AES widths, FSM encodings, Rcon and S-box helpers
package aes_key_store_pkg;

   localparam int AES_BLOCK_W   = 128;
   localparam int AES128_ROUNDS = 10;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EXPAND = 2'd1,
      FLUSH  = 2'd2,
      READY  = 2'd3
   } state_e;

   function automatic logic [7:0] rcon(input logic [3:0] r);
      case (r)
         4'd1:    rcon = 8'h01;
         4'd2:    rcon = 8'h02;
         4'd3:    rcon = 8'h04;
         4'd4:    rcon = 8'h08;
         4'd5:    rcon = 8'h10;
         4'd6:    rcon = 8'h20;
         4'd7:    rcon = 8'h40;
         4'd8:    rcon = 8'h80;
         4'd9:    rcon = 8'h1b;
         4'd10:   rcon = 8'h36;
         default: rcon = 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // S-box as multiplicative inverse (x^254, which maps 0 to 0) followed by the affine map
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] r;
      logic [7:0] e;
      r = 8'h01;
      e = 8'hfe;
      for (int i = 7; i >= 0; i--) begin
         r = gf_mul(r, r);
         if (e[i]) r = gf_mul(r, x);
      end
      return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
   endfunction

endpackage

// File: rtl/aes_key_store_key_exp.sv
// aes_key_store_key_exp: one AES-128 key schedule round with a registered output
module aes_key_store_key_exp
   import aes_key_store_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic [3:0]             round_num,
   input  logic [0:AES_BLOCK_W-1] key_in,
   output logic [0:AES_BLOCK_W-1] round_key
);

   logic [31:0]            w0, w1, w2, w3, t, n0, n1, n2, n3;
   logic [0:AES_BLOCK_W-1] round_key_d, round_key_q;

   // round 0 passes the cipher key through; later rounds derive the next key from the previous one
   always_comb begin
      w0          = key_in[0:31];
      w1          = key_in[32:63];
      w2          = key_in[64:95];
      w3          = key_in[96:127];
      t           = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rcon(round_num), 24'h0};
      n0          = w0 ^ t;
      n1          = w1 ^ n0;
      n2          = w2 ^ n1;
      n3          = w3 ^ n2;
      round_key_d = !en ? round_key_q : (round_num == 4'd0 ? key_in : {n0, n1, n2, n3});
   end

   // output register gives the one-cycle expansion latency
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) round_key_q <= '0;
      else        round_key_q <= round_key_d;
   end

   assign round_key = round_key_q;

endmodule

// File: rtl/aes_key_store.sv
// aes_key_store: sequences key expansion and holds all round keys behind a registered read port
module aes_key_store
   import aes_key_store_pkg::*;
#(
   parameter int NUM_ROUNDS = AES128_ROUNDS,
   parameter int IDX_W      = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   key_valid,
   input  logic [0:AES_BLOCK_W-1] key_in,
   output logic                   key_ready,
   input  logic                   key_clear,
   output logic                   busy,
   output logic                   keys_ready,
   input  logic                   rd_en,
   input  logic [IDX_W-1:0]       rd_idx,
   output logic [0:AES_BLOCK_W-1] rd_key,
   output logic                   rd_valid
);

   localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_ROUNDS);

   state_e                 state_d, state_q;
   logic [IDX_W-1:0]       cnt_d, cnt_q, wr_ptr_d, wr_ptr_q;
   logic                   wr_en_d, wr_en_q, keys_ready_d, keys_ready_q, rd_valid_d, rd_valid_q;
   logic [0:AES_BLOCK_W-1] base_key_d, base_key_q, rd_key_d, rd_key_q, ke_key, ke_round_key;
   logic [0:AES_BLOCK_W-1] store_d [0:NUM_ROUNDS];
   logic [0:AES_BLOCK_W-1] store_q [0:NUM_ROUNDS];

   aes_key_store_key_exp u_key_exp (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (state_q == EXPAND),
      .round_num (cnt_q),
      .key_in    (ke_key),
      .round_key (ke_round_key)
   );

   assign ke_key     = cnt_q == '0 ? base_key_q : ke_round_key;
   assign key_ready  = state_q == IDLE || state_q == READY;
   assign busy       = state_q == EXPAND || state_q == FLUSH;
   assign keys_ready = keys_ready_q;
   assign rd_key     = rd_key_q;
   assign rd_valid   = rd_valid_q;

   // sequencer; the store write trails the expansion round by one cycle, and a clear overrides everything
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      base_key_d   = base_key_q;
      wr_en_d      = 1'b0;
      wr_ptr_d     = wr_ptr_q;
      keys_ready_d = keys_ready_q;
      store_d      = store_q;
      if (wr_en_q && !key_clear) store_d[wr_ptr_q] = ke_round_key;
      if (key_clear) begin
         state_d      = IDLE;
         cnt_d        = '0;
         keys_ready_d = 1'b0;
      end else if (key_ready && key_valid) begin
         state_d      = EXPAND;
         cnt_d        = '0;
         base_key_d   = key_in;
         keys_ready_d = 1'b0;
      end else if (state_q == EXPAND) begin
         cnt_d    = cnt_q + IDX_W'(1);
         wr_en_d  = 1'b1;
         wr_ptr_d = cnt_q;
         state_d  = cnt_q == LAST ? FLUSH : EXPAND;
      end else if (state_q == FLUSH) begin
         state_d      = READY;
         keys_ready_d = 1'b1;
      end
   end

   // read port: invalid reads hold the last data, out-of-range reads return zero
   always_comb begin
      rd_valid_d = rd_en && keys_ready_q && !key_clear;
      rd_key_d   = !rd_valid_d ? rd_key_q : (rd_idx <= LAST ? store_q[rd_idx] : '0);
   end

   // state, store and read registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         base_key_q   <= '0;
         wr_en_q      <= 1'b0;
         wr_ptr_q     <= '0;
         keys_ready_q <= 1'b0;
         rd_valid_q   <= 1'b0;
         rd_key_q     <= '0;
         store_q      <= '{default: '0};
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         base_key_q   <= base_key_d;
         wr_en_q      <= wr_en_d;
         wr_ptr_q     <= wr_ptr_d;
         keys_ready_q <= keys_ready_d;
         rd_valid_q   <= rd_valid_d;
         rd_key_q     <= rd_key_d;
         store_q      <= store_d;
      end
   end

endmodule

// File: tb/tb_aes_key_store.sv
// tb_aes_key_store: directed vectors with a read scoreboard for aes_key_store
module tb_aes_key_store;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         key_valid = 1'b0;
   logic [0:127] key_in = '0;
   logic         key_ready;
   logic         key_clear = 1'b0;
   logic         busy;
   logic         keys_ready;
   logic         rd_en = 1'b0;
   logic [3:0]   rd_idx = '0;
   logic [0:127] rd_key;
   logic         rd_valid;

   int checks = 0;
   int fails  = 0;

   logic [0:127] exp_q [$];
   string        tag_q [$];
   logic [0:127] mon_exp;
   string        mon_tag;

   logic [0:127] fips [0:10] = '{
      128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
      128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
      128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
      128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
      128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
      128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
   logic [0:127] zero1  = 128'h62636363626363636263636362636363;
   logic [0:127] zero10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

   aes_key_store dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_valid  (key_valid),
      .key_in     (key_in),
      .key_ready  (key_ready),
      .key_clear  (key_clear),
      .busy       (busy),
      .keys_ready (keys_ready),
      .rd_en      (rd_en),
      .rd_idx     (rd_idx),
      .rd_key     (rd_key),
      .rd_valid   (rd_valid)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish, required completion");
      $fatal(1);
   end

   // monitor: every valid read must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (rst_n && rd_valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_rd_valid: got rd_key=%h, required no valid read", rd_key);
         end else begin
            mon_exp = exp_q.pop_front();
            mon_tag = tag_q.pop_front();
            if (rd_key !== mon_exp) begin
               fails++;
               $display("FAIL %s: got %h, required %h", mon_tag, rd_key, mon_exp);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h", name, got, exp);
      end
   endtask

   task automatic rd(input logic [3:0] idx, input logic [0:127] exp, input string name);
      @(posedge clk);
      #1;
      rd_en  = 1'b1;
      rd_idx = idx;
      exp_q.push_back(exp);
      tag_q.push_back(name);
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
      rd_en = 1'b0;
   endtask

   task automatic start(input logic [0:127] k);
      @(posedge clk);
      #1;
      key_valid = 1'b1;
      key_in    = k;
      @(posedge clk);
      #1;
      key_valid = 1'b0;
      chk("busy_after_accept", {127'b0, busy}, 128'd1);
   endtask

   task automatic wait_ready(input int n, input string name);
      int c;
      c = 0;
      while (!keys_ready && c < 40) begin
         @(posedge clk);
         #1;
         c++;
      end
      chk(name, 128'(c), 128'(n));
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("reset_key_ready", {127'b0, key_ready}, 128'd1);
      chk("reset_busy", {127'b0, busy}, 128'd0);
      chk("reset_keys_ready", {127'b0, keys_ready}, 128'd0);
      chk("reset_rd_valid", {127'b0, rd_valid}, 128'd0);
      chk("reset_rd_key", rd_key, 128'd0);
      @(negedge clk);
      rst_n = 1'b1;

      start(fips[0]);
      wait_ready(12, "fips_latency");
      rd(4'd0, fips[0], "fips_rk0");
      rd(4'd1, fips[1], "fips_rk1");
      rd(4'd10, fips[10], "fips_rk10");
      rd(4'd11, 128'd0, "idx11_zero");
      idle();
      for (int i = 10; i >= 0; i--) rd(4'(i), fips[i], $sformatf("desc_rk%0d", i));
      idle();

      start(128'd0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         key_valid = 1'b1;
         key_in    = fips[0];
         chk("key_ready_in_expand", {127'b0, key_ready}, 128'd0);
      end
      @(posedge clk);
      #1;
      key_valid = 1'b0;
      wait_ready(8, "zero_latency");
      rd(4'd1, zero1, "zero_rk1");
      rd(4'd10, zero10, "zero_rk10");
      idle();

      @(posedge clk);
      #1;
      key_valid = 1'b1;
      key_in    = fips[0];
      rd_en     = 1'b1;
      rd_idx    = 4'd10;
      exp_q.push_back(zero10);
      tag_q.push_back("same_edge_old_key");
      @(posedge clk);
      #1;
      key_valid = 1'b0;
      rd_en     = 1'b0;
      chk("keys_ready_drops", {127'b0, keys_ready}, 128'd0);
      repeat (5) @(posedge clk);
      #1;
      key_clear = 1'b1;
      @(posedge clk);
      #1;
      key_clear = 1'b0;
      chk("clear_busy", {127'b0, busy}, 128'd0);
      chk("clear_keys_ready", {127'b0, keys_ready}, 128'd0);
      chk("clear_key_ready", {127'b0, key_ready}, 128'd1);
      rd_en  = 1'b1;
      rd_idx = 4'd1;
      @(posedge clk);
      #1;
      rd_en = 1'b0;
      chk("clear_rd_valid", {127'b0, rd_valid}, 128'd0);
      start(fips[0]);
      wait_ready(12, "after_clear_latency");
      rd(4'd5, fips[5], "after_clear_rk5");
      rd(4'd10, fips[10], "after_clear_rk10");
      idle();

      start(128'd0);
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_key_ready", {127'b0, key_ready}, 128'd1);
      chk("async_busy", {127'b0, busy}, 128'd0);
      chk("async_keys_ready", {127'b0, keys_ready}, 128'd0);
      chk("async_rd_valid", {127'b0, rd_valid}, 128'd0);
      chk("async_rd_key", rd_key, 128'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      rd_en  = 1'b1;
      rd_idx = 4'd0;
      @(posedge clk);
      #1;
      rd_en = 1'b0;
      chk("post_reset_rd_valid", {127'b0, rd_valid}, 128'd0);
      chk("post_reset_rd_key", rd_key, 128'd0);

      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_drained", 128'(exp_q.size()), 128'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
